// File: rtl/alu_issue_if.sv
// Handshake and operand bus between the register-read stage, the issue buffer and the ALU.
// The driver of in_* and out_ready takes master; the issue stage takes slave.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [3:0]  out_op_code;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_illegal;

  modport master (
    output in_valid, in_instr, in_rs1_data, in_rs2_data, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_op_code, out_rd, out_we, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_rs1_data, in_rs2_data, out_ready,
    output in_ready, out_valid, out_a, out_b, out_op_code, out_rd, out_we, out_illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I OP/OP-IMM decoder feeding a two-entry skid buffer towards the ALU.
// state | meaning
// EMPTY | nothing buffered, out_valid low
// ONE   | main entry presented, skid free
// FULL  | main presented, skid holds the next entry, in_ready low
module alu_issue_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  alu_issue_if.slave   bus,
  output logic [7:0]   illegal_count
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        we;
    logic        illegal;
  } entry_t;

  state_t state_q, state_d;
  entry_t main_q, skid_q, dec;
  logic   in_ready_q;
  logic   accept, drain, out_valid;
  logic   load_main, load_skid, move_skid;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       legal;
  logic [3:0] op;
  logic [31:0] operand_b;

  assign opcode = bus.in_instr[6:0];
  assign funct3 = bus.in_instr[14:12];
  assign funct7 = bus.in_instr[31:25];

  always_comb begin
    legal     = 1'b0;
    op        = 4'b1111;
    operand_b = bus.in_rs2_data;
    if (opcode == 7'b0110011) begin
      legal = (funct7 == 7'b0000000) ||
              (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
      case (funct3)
        3'b000:  op = funct7[5] ? 4'b0001 : 4'b0000;
        3'b001:  op = 4'b0101;
        3'b010:  op = 4'b1000;
        3'b011:  op = 4'b1001;
        3'b100:  op = 4'b0100;
        3'b101:  op = funct7[5] ? 4'b0111 : 4'b0110;
        3'b110:  op = 4'b0011;
        default: op = 4'b0010;
      endcase
    end else if (opcode == 7'b0010011) begin
      operand_b = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
      legal     = 1'b1;
      case (funct3)
        3'b000:  op = 4'b0000;
        3'b001: begin
          op        = 4'b0101;
          legal     = (funct7 == 7'b0000000);
          operand_b = {27'b0, bus.in_instr[24:20]};
        end
        3'b010:  op = 4'b1000;
        3'b011:  op = 4'b1001;
        3'b100:  op = 4'b0100;
        3'b101: begin
          op        = funct7[5] ? 4'b0111 : 4'b0110;
          legal     = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          operand_b = {27'b0, bus.in_instr[24:20]};
        end
        3'b110:  op = 4'b0011;
        default: op = 4'b0010;
      endcase
    end
  end

  always_comb begin
    dec.rd = bus.in_instr[11:7];
    if (legal) begin
      dec.a       = bus.in_rs1_data;
      dec.b       = operand_b;
      dec.op      = op;
      dec.we      = (bus.in_instr[11:7] != 5'd0);
      dec.illegal = 1'b0;
    end else begin
      dec.a       = 32'd0;
      dec.b       = 32'd0;
      dec.op      = 4'b1111;
      dec.we      = 1'b0;
      dec.illegal = 1'b1;
    end
  end

  // A flush swallows any handshake offered in the same cycle.
  assign out_valid = (state_q != EMPTY);
  assign accept    = bus.in_valid && in_ready_q && !flush;
  assign drain     = out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) state_d = EMPTY;
    else begin
      case (state_q)
        EMPTY:   if (accept) state_d = ONE;
        ONE:     if (accept && !drain) state_d = FULL;
                 else if (!accept && drain) state_d = EMPTY;
        FULL:    if (drain) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (!flush) begin
      load_main = accept && ((state_q == EMPTY) || (state_q == ONE && drain));
      load_skid = accept && (state_q == ONE) && !drain;
      move_skid = (state_q == FULL) && drain;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q        <= '0;
      skid_q        <= '0;
      in_ready_q    <= 1'b1;
      illegal_count <= 8'd0;
    end else begin
      if (load_main)      main_q <= dec;
      else if (move_skid) main_q <= skid_q;
      if (load_skid)      skid_q <= dec;
      in_ready_q <= (state_d != FULL);
      if (accept && dec.illegal && illegal_count != 8'hFF)
        illegal_count <= illegal_count + 8'd1;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid;
  assign bus.out_a       = main_q.a;
  assign bus.out_b       = main_q.b;
  assign bus.out_op_code = main_q.op;
  assign bus.out_rd      = main_q.rd;
  assign bus.out_we      = main_q.we;
  assign bus.out_illegal = main_q.illegal;
endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have: flush  in  1  synchronous discard of all buffered entries.
REQ-004 SHALL have: in_valid  in  1 / in_ready  out  1  upstream handshake.
REQ-005 SHALL have: in_instr  in  32  RV32I instruction word.
REQ-006 SHALL have: in_rs1_data, in_rs2_data  in  32 each  register-file read data.
REQ-007 SHALL have: out_valid  out  1 / out_ready  in  1  downstream (ALU side) handshake.
REQ-008 SHALL have: out_a, out_b  out  32 each  ALU operands.
REQ-009 SHALL have: out_op_code  out  4  ALU op; out_rd  out  5  destination; out_we  out  1  writeback enable.
REQ-010 SHALL have: out_illegal  out  1  entry failed decode; illegal_count  out  8  saturating counter.

Function
REQ-011 SHALL accept an entry when in_valid && in_ready; SHALL present it when out_valid && out_ready.
REQ-012 SHALL decode opcode 0110011 (OP) and 0010011 (OP-IMM) only; all else illegal.
REQ-013 op_code map SHALL be ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, illegal 1111.
REQ-014 funct3 map: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
REQ-015 OP: funct7 0000000 legal for all funct3; 0100000 legal only for funct3 000 (SUB) and 101 (SRA); else illegal.
REQ-016 OP-IMM: funct3 000 is ADD always; 001 requires imm[11:5]=0000000; 101 requires 0000000 (SRL) or 0100000 (SRA); else illegal.
REQ-017 out_a SHALL be in_rs1_data; out_b SHALL be in_rs2_data (OP), sign-extended instr[31:20] (OP-IMM non-shift), or {27'b0, instr[24:20]} (OP-IMM shift).
REQ-018 Illegal entry SHALL carry out_op_code 1111, out_a=out_b=0, out_we=0, out_illegal=1, out_rd=instr[11:7].
REQ-019 out_we SHALL be 1 for legal entries with rd!=0, 0 when rd=0.
REQ-020 Buffer SHALL be a 2-entry skid (main+skid) with states EMPTY, ONE, FULL; latency in_instr accept to out_valid = 1 cycle.
REQ-021 EMPTY: accept -> ONE. ONE: accept without drain -> FULL; drain without accept -> EMPTY; both -> ONE with new entry.
REQ-022 FULL: drain -> ONE (skid moves to main); in_ready=0 so no accept.
REQ-023 in_ready SHALL be registered, high in EMPTY and ONE, low in FULL; no combinational path from out_ready.
REQ-024 Entries SHALL exit in acceptance order; none lost or duplicated under any out_ready pattern.
REQ-025 Outputs SHALL hold stable while out_valid && !out_ready.
REQ-026 illegal_count SHALL increment by 1 on each accepted illegal entry, saturate at 255, unaffected by flush.
REQ-027 flush SHALL force EMPTY next cycle and drop any same-cycle accept; flush has priority over handshakes.

Reset
REQ-028 rst SHALL have priority over flush and all handshakes.
REQ-029 Reset values: state EMPTY, out_valid 0, in_ready 1, out_a 0, out_b 0, out_op_code 0000, out_rd 0, out_we 0, out_illegal 0, illegal_count 0.
REQ-030 Handshakes in a cycle with rst high SHALL be ignored; reset mid-stream SHALL discard all buffered entries.

Verification
REQ-031 ADD: instr 0x002081B3, rs1=2, rs2=3, out_ready=1 -> next cycle out_valid=1, a=2, b=3, op 0000, rd 3, we 1; ALU yields 5.
REQ-032 ADDI x5,x0,-1: instr 0xFFF00293, rs1=0 -> a=0, b=0xFFFFFFFF, op 0000, rd 5, we 1.
REQ-033 SRAI: instr 0x4010D093, rs1=0x80000000 -> a=0x80000000, b=1, op 0111, rd 1; ALU yields 0xC0000000.
REQ-034 Illegal: instr 0xFFFFFFFF -> op 1111, a=b=0, we 0, illegal 1, illegal_count 0 -> 1; 300 illegal entries -> count 255.
REQ-035 Backpressure: out_ready=0, three back-to-back inputs -> in_ready low after 2nd accept, third held upstream; out_ready=1 -> all three out in order.
REQ-036 FULL then flush (or rst) -> next cycle out_valid=0, in_ready=1; flushed entries never appear.
